sprite_drawer: RTL and testbench

Parametrised sprite address generator and pixel gate for the VGA path. It compares `hcount`/`vcount` against a sprite bounding box whose position, animation frame and mirror mode are latched once per video frame. It drives a synchronous sprite ROM and outputs the returned pixel with a `draw` qualifier that honours a transparent colour key. It sits between the VGA sync counter and the colour mux, one instance per on-screen sprite (ducks, crosshair, dog).

---
 rtl/vga_pkg.sv | 19 +
 rtl/sprite_addr_gen.sv | 115 +++++++++++
 rtl/sprite_drawer.sv | 85 ++++++++
 tb/tb_sprite_drawer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared VGA timing constants and pixel type for the video path.
//   H_TOTAL/V_TOTAL : raster period in clocks / lines
//   H_ACTIVE/V_ACTIVE : visible area
//   TRANSP : default transparent colour key (RRGGBB)
//   pixel_t : one RRGGBB pixel
package vga_pkg;

   localparam int H_TOTAL  = 800;
   localparam int V_TOTAL  = 525;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   localparam int PIX_W = 6;
   typedef logic [PIX_W-1:0] pixel_t;

   localparam pixel_t TRANSP = 6'h3F;

endpackage

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen
//   Per-frame shadow latch of sprite position/frame/mirror, bounding-box
//   compare and incremental ROM address generation (no per-pixel multiply).
//   Ports:
//     clk, reset           pixel clock, async active-low reset
//     hcount, vcount       raster position (sampled cycle n)
//     pos_x, pos_y         sprite top-left, latched on the latch line
//     frame_sel, mirror    animation frame / horizontal flip, latched likewise
//     rom_addr             registered ROM address (valid cycle n+1)
//     in_box               registered in-box flag aligned with rom_addr
module sprite_addr_gen
   import vga_pkg::*;
#(
   parameter int SPR_W   = 124,
   parameter int SPR_H   = 162,
   parameter int FRAMES  = 2,
   parameter int ADDR_W  = 16,
   parameter int H_TOTAL = vga_pkg::H_TOTAL,
   parameter int V_LATCH = vga_pkg::V_ACTIVE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [9:0]        hcount,
   input  logic [9:0]        vcount,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   input  logic [1:0]        frame_sel,
   input  logic              mirror,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              in_box
);

   localparam int          FRAME_SZ = SPR_W * SPR_H;
   localparam logic [10:0] W11      = 11'(SPR_W);
   localparam logic [10:0] H11      = 11'(SPR_H);
   localparam logic [10:0] WM1      = 11'(SPR_W - 1);
   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAT    = 10'(V_LATCH);

   // Shadows. The frame shadow is kept only as its ROM base address.
   logic [9:0]        x_l, y_l;
   logic              mir_l;
   logic              armed;          // set by the first latch after reset
   logic [ADDR_W-1:0] frame_base;
   logic [ADDR_W-1:0] row_off;

   logic              latch;
   logic [1:0]        frame_c;
   logic [ADDR_W-1:0] fbase_c;
   logic [9:0]        x_e, y_e;
   logic              mir_e, armed_e;
   logic [ADDR_W-1:0] fb_e, ro_e;
   logic [10:0]       h11, v11, x11, y11, rel, col;
   logic              hit, row_in;
   logic [ADDR_W-1:0] addr_c;

   always_comb begin
      latch   = (vcount == V_LAT) && (hcount == '0);
      frame_c = (int'(frame_sel) >= FRAMES) ? 2'(FRAMES - 1) : frame_sel;
      fbase_c = ADDR_W'(int'(frame_c) * FRAME_SZ);

      // On the latch cycle the incoming values are already in force, so a
      // sprite whose box starts on that very cycle draws with the new state.
      x_e     = latch ? pos_x   : x_l;
      y_e     = latch ? pos_y   : y_l;
      mir_e   = latch ? mirror  : mir_l;
      armed_e = latch | armed;
      fb_e    = latch ? fbase_c : frame_base;
      ro_e    = latch ? '0      : row_off;

      h11 = {1'b0, hcount};
      v11 = {1'b0, vcount};
      x11 = {1'b0, x_e};
      y11 = {1'b0, y_e};

      // 11-bit compare: boxes running past 1023 are clipped, never wrapped.
      hit = armed_e && (h11 >= x11) && (h11 < x11 + W11)
                    && (v11 >= y11) && (v11 < y11 + H11);

      rel    = h11 - x11;
      col    = mir_e ? (WM1 - rel) : rel;
      addr_c = fb_e + ro_e + ADDR_W'(col);

      row_in = (v11 >= {1'b0, y_l}) && (v11 < {1'b0, y_l} + H11);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_l        <= '0;
         y_l        <= '0;
         mir_l      <= 1'b0;
         armed      <= 1'b0;
         frame_base <= '0;
         row_off    <= '0;
         rom_addr   <= '0;
         in_box     <= 1'b0;
      end else begin
         in_box <= hit;
         if (hit)
            rom_addr <= addr_c;

         if (latch) begin
            x_l        <= pos_x;
            y_l        <= pos_y;
            mir_l      <= mirror;
            armed      <= 1'b1;
            frame_base <= fbase_c;
            row_off    <= '0;
         end else if ((hcount == H_LAST) && row_in) begin
            row_off <= row_off + ADDR_W'(SPR_W);
         end
      end
   end

endmodule

// File: rtl/sprite_drawer.sv
// sprite_drawer
//   Sprite address generator plus transparency-gated pixel output.
//   Latency hcount/vcount -> pixel/draw is 3 clocks.
//   Ports:
//     clk, reset          pixel clock, async active-low reset
//     hcount, vcount      raster position
//     enable              sprite visible (sampled with hcount/vcount)
//     pos_x, pos_y        sprite top-left (latched once per frame)
//     frame_sel, mirror   animation frame, horizontal flip (latched)
//     rom_addr            registered sprite ROM address
//     rom_data            ROM read data, one cycle after rom_addr
//     pixel               registered pixel colour (0 when not drawn)
//     draw                pixel is opaque and inside the box
module sprite_drawer
   import vga_pkg::*;
#(
   parameter int               SPR_W   = 124,
   parameter int               SPR_H   = 162,
   parameter int               FRAMES  = 2,
   parameter int               DATA_W  = 6,
   parameter int               ADDR_W  = 16,
   parameter logic [DATA_W-1:0] TRANSP = DATA_W'(vga_pkg::TRANSP),
   parameter int               H_TOTAL = vga_pkg::H_TOTAL,
   parameter int               V_LATCH = 480
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [9:0]        hcount,
   input  logic [9:0]        vcount,
   input  logic              enable,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   input  logic [1:0]        frame_sel,
   input  logic              mirror,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] pixel,
   output logic              draw
);

   logic in_box_d1, in_box_d2;
   logic en_d1, en_d2;
   logic opaque;

   sprite_addr_gen #(
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H),
      .FRAMES  (FRAMES),
      .ADDR_W  (ADDR_W),
      .H_TOTAL (H_TOTAL),
      .V_LATCH (V_LATCH)
   ) u_addr (
      .clk       (clk),
      .reset     (reset),
      .hcount    (hcount),
      .vcount    (vcount),
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .frame_sel (frame_sel),
      .mirror    (mirror),
      .rom_addr  (rom_addr),
      .in_box    (in_box_d1)
   );

   always_comb begin
      opaque = in_box_d2 && en_d2 && (rom_data != TRANSP);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_d1     <= 1'b0;
         en_d2     <= 1'b0;
         in_box_d2 <= 1'b0;
         draw      <= 1'b0;
         pixel     <= '0;
      end else begin
         en_d1     <= enable;
         en_d2     <= en_d1;
         in_box_d2 <= in_box_d1;
         draw      <= opaque;
         pixel     <= opaque ? rom_data : '0;
      end
   end

endmodule

// File: tb/tb_sprite_drawer.sv
module tb_sprite_drawer;

   localparam int W     = 124;
   localparam int H     = 162;
   localparam int FSZ   = W * H;
   localparam int LATCH = 480;
   localparam int VT    = 525;
   localparam int HLAST = 799;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  hcount, vcount, pos_x, pos_y;
   logic [1:0]  frame_sel;
   logic        mirror, enable;
   logic [15:0] rom_addr;
   logic [5:0]  rom_data, pixel;
   logic        draw;

   always #5 clk = ~clk;

   sprite_drawer #(
      .SPR_W(124), .SPR_H(162), .FRAMES(2), .DATA_W(6), .ADDR_W(16),
      .TRANSP(6'h3F), .H_TOTAL(800), .V_LATCH(480)
   ) dut (
      .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
      .enable(enable), .pos_x(pos_x), .pos_y(pos_y), .frame_sel(frame_sel),
      .mirror(mirror), .rom_addr(rom_addr), .rom_data(rom_data),
      .pixel(pixel), .draw(draw)
   );

   // Synchronous sprite ROM: every 7th word is the transparent key.
   function automatic logic [5:0] rom_val(input int a);
      if (a % 7 == 3) return 6'h3F;
      return 6'(a % 63);
   endfunction

   always @(posedge clk) rom_data <= rom_val(int'(rom_addr));

   // Reference model state: latched sprite, last address, output pipe.
   typedef struct { bit vis; int addr; } pend_t;
   int    m_x, m_y, m_f, m_mir;
   bit    m_armed;
   int    m_last;
   pend_t q[$];

   int tests = 0;
   int fails = 0;

   typedef struct {
      int px, py, fs, mir, en_rand, rst_line;
      int ph0, pv0, pa0, ph1, pv1, pa1;
   } vec_t;
   vec_t tbl[7];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s h=%0d v=%0d: got %0d expected %0d",
                  name, hcount, vcount, act, exp);
      end
   endtask

   task automatic model_reset();
      m_armed = 1'b0;
      m_last  = 0;
      q.delete();
      q.push_back('{1'b0, 0});
      q.push_back('{1'b0, 0});
   endtask

   task automatic step(input int h, input int v, input bit en);
      pend_t e;
      bit    inb;
      int    c, d, p, val;
      hcount = 10'(h);
      vcount = 10'(v);
      enable = en;
      if (v == LATCH && h == 0) begin
         m_x     = int'(pos_x);
         m_y     = int'(pos_y);
         m_f     = (frame_sel >= 2) ? 1 : int'(frame_sel);
         m_mir   = int'(mirror);
         m_armed = 1'b1;
      end
      inb = m_armed && h >= m_x && h < m_x + W && v >= m_y && v < m_y + H;
      if (inb) begin
         c      = m_mir ? (W - 1 - (h - m_x)) : (h - m_x);
         m_last = m_f * FSZ + (v - m_y) * W + c;
      end
      q.push_back('{inb && en, m_last});
      @(posedge clk);
      #1;
      check("rom_addr", int'(rom_addr), m_last);
      e   = q.pop_front();
      val = int'(rom_val(e.addr));
      d   = (e.vis && val != 63) ? 1 : 0;
      p   = d ? val : 0;
      check("draw", int'(draw), d);
      check("pixel", int'(pixel), p);
   endtask

   task automatic add_col(inout int cols[$], input int c);
      if (c >= 0 && c < 1024 && c != HLAST) cols.push_back(c);
   endtask

   task automatic run_frame(input vec_t t);
      int cols[$];
      int v;
      bit en;
      pos_x     = 10'(t.px);
      pos_y     = 10'(t.py);
      frame_sel = 2'(t.fs);
      mirror    = t.mir[0];
      for (int li = 0; li < VT; li++) begin
         v = (LATCH + li) % VT;
         if (v == 100) begin
            // Mid-frame input changes must not move the latched sprite.
            pos_x     = 10'($urandom_range(0, 1023));
            pos_y     = 10'($urandom_range(0, 1023));
            frame_sel = 2'($urandom_range(0, 3));
            mirror    = 1'($urandom_range(0, 1));
         end
         cols.delete();
         cols.push_back(0);
         add_col(cols, $urandom_range(0, 99));
         add_col(cols, $urandom_range(0, 1023));
         add_col(cols, t.px - 1);
         add_col(cols, t.px);
         add_col(cols, t.px + 1);
         add_col(cols, t.px + $urandom_range(0, W - 1));
         add_col(cols, t.px + W - 1);
         add_col(cols, t.px + W);
         if (v == t.pv0) add_col(cols, t.ph0);
         if (v == t.pv1) add_col(cols, t.ph1);
         cols.push_back(HLAST);
         for (int ci = 0; ci < cols.size(); ci++) begin
            en = t.en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            step(cols[ci], v, en);
            if (v == t.pv0 && cols[ci] == t.ph0) check("probe0", int'(rom_addr), t.pa0);
            if (v == t.pv1 && cols[ci] == t.ph1) check("probe1", int'(rom_addr), t.pa1);
            if (v == t.rst_line && ci == 3) begin
               #2 reset = 1'b0;
               #1;
               check("rst_rom_addr", int'(rom_addr), 0);
               check("rst_draw", int'(draw), 0);
               check("rst_pixel", int'(pixel), 0);
               #1 reset = 1'b1;
               model_reset();
            end
         end
      end
   endtask

   initial begin
      //          px   py  fs mir enr rst   probe0            probe1
      tbl[0] = '{100,  50, 0, 0,  0,  -1,  100,  50, 0,      223, 211, 20087};
      tbl[1] = '{100,  50, 1, 1,  0,  -1,  100,  50, 20211,  223,  50, 20088};
      tbl[2] = '{600,  60, 0, 1,  0,  -1,  600,  60, 123,    723,  61, 124};
      tbl[3] = '{0,   480, 1, 0,  0,  -1,    0, 480, 20088,    5, 481, 20217};
      tbl[4] = '{100,  50, 3, 0,  1,  -1,  100,  50, 20088,  101,  51, 20213};
      tbl[5] = '{950, 100, 0, 0,  1, 130,  950, 100, 0,     1023, 101, 197};
      tbl[6] = '{300, 200, 1, 0,  0,  -1,  300, 200, 20088,  423, 361, 40175};

      reset     = 1'b0;
      hcount    = '0;
      vcount    = '0;
      enable    = 1'b1;
      pos_x     = '0;
      pos_y     = '0;
      frame_sel = '0;
      mirror    = 1'b0;
      m_x = 0; m_y = 0; m_f = 0; m_mir = 0;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check("reset_rom_addr", int'(rom_addr), 0);
      check("reset_draw", int'(draw), 0);
      check("reset_pixel", int'(pixel), 0);
      @(negedge clk);
      reset = 1'b1;

      // Unlatched after reset: a box at the origin must not appear.
      for (int i = 0; i < 8; i++) step(i * 10, 5, 1'b1);

      for (int i = 0; i < 7; i++) run_frame(tbl[i]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
